mem_access_unit: RTL and testbench

Memory-stage load/store unit of the 5-stage MIPS pipeline, sitting between the EX/MEM register and the MEM/WB register. Turns the memory-stage control and address into a request/acknowledge transaction on the data-memory bus. Handles byte/half/word lane selection and sign/zero extension, and stalls the upstream pipeline until the bus acknowledges. Its write-back outputs feed the MEM/WB register inputs directly: read data, ALU result, destination register, mem2reg and regwr.

---
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: drives a req/ack data bus, does lane select and extension, stalls until ack.
// Optional MEM_ALIGN_TRAP_EN: misaligned half/word accesses fault without issuing a bus request.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_res,
  input  logic [31:0] store_data,
  input  logic [4:0]  dst_reg,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_sext,
  input  logic        mem2reg_in,
  input  logic        regwr_in,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] rdata_out,
  output logic [31:0] alu_out,
  output logic [4:0]  dst_out,
  output logic        mem2reg_out,
  output logic        regwr_out,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  typedef struct packed {
    logic       ld;
    logic [1:0] size;
    logic       sext;
    logic [1:0] lane;
  } op_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  op_t         op_q;
  logic [15:0] cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        access;
  logic        misalign;
  logic [31:0] wdata_n;
  logic [3:0]  be_n;
  logic [31:0] rd_sh;
  logic [31:0] ld_ext;

  assign access = valid_in & (mem_rd | mem_wr);

`ifdef MEM_ALIGN_TRAP_EN
  assign misalign = ((mem_size == 2'b01) & alu_res[0]) |
                    (mem_size[1] & (alu_res[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Store data replicated into every lane; enables pick the live lanes.
  always_comb begin
    wdata_n = store_data;
    be_n    = 4'b1111;
    case (mem_size)
      2'b00: begin
        wdata_n = {4{store_data[7:0]}};
        be_n    = 4'b0001 << alu_res[1:0];
      end
      2'b01: begin
        wdata_n = {2{store_data[15:0]}};
        be_n    = alu_res[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign rd_sh = bus_rdata >> {op_q.lane, 3'b000};

  always_comb begin
    ld_ext = bus_rdata;
    case (op_q.size)
      2'b00: ld_ext = {{24{op_q.sext & rd_sh[7]}}, rd_sh[7:0]};
      2'b01: ld_ext = op_q.lane[1] ? {{16{op_q.sext & bus_rdata[31]}}, bus_rdata[31:16]}
                                   : {{16{op_q.sext & bus_rdata[15]}}, bus_rdata[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_q      <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      case (state)
        IDLE: if (access) begin
          op_q <= '{ld: ~mem_wr, size: mem_size, sext: mem_sext, lane: alu_res[1:0]};
          cnt  <= '0;
          if (misalign) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            bus_req   <= 1'b1;
            bus_we    <= mem_wr;
            bus_addr  <= {alu_res[31:2], 2'b00};
            bus_wdata <= mem_wr ? wdata_n : 32'h0;
            bus_be    <= be_n;
            state     <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 16'd1;
          // An ack in the final allowed cycle still completes normally.
          if (bus_ack || (TIMEOUT_CYC != 0 && cnt == TO_LAST)) begin
            rdata_q   <= (bus_ack && op_q.ld) ? ld_ext : 32'h0;
            err_q     <= ~bus_ack;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          cnt     <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    regwr_out = 1'b0;
    case (state)
      IDLE:    regwr_out = regwr_in & ~access;
      DONE:    regwr_out = regwr_in & ~err_q;
      default: regwr_out = 1'b0;
    endcase
    regwr_out = regwr_out & rst;
  end

  assign stall       = rst & (((state == IDLE) & access) | (state == REQ));
  assign rdata_out   = rdata_q;
  assign err         = err_q;
  assign alu_out     = alu_res;
  assign dst_out     = dst_reg;
  assign mem2reg_out = mem2reg_in;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (timeout shortened to 4 cycles); expectations are hand-derived.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_res, store_data;
  logic [4:0]  dst_reg;
  logic        mem_rd, mem_wr, mem_sext, mem2reg_in, regwr_in;
  logic [1:0]  mem_size;
  logic        stall, bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic [31:0] rdata_out, alu_out;
  logic [4:0]  dst_out;
  logic        mem2reg_out, regwr_out, err;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_res(alu_res), .store_data(store_data),
    .dst_reg(dst_reg), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size), .mem_sext(mem_sext),
    .mem2reg_in(mem2reg_in), .regwr_in(regwr_in), .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .rdata_out(rdata_out), .alu_out(alu_out), .dst_out(dst_out),
    .mem2reg_out(mem2reg_out), .regwr_out(regwr_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] sd);
    valid_in = 1'b1; mem_rd = rd; mem_wr = wr; mem_size = sz; mem_sext = sx;
    alu_res = a; store_data = sd; regwr_in = rd & ~wr; mem2reg_in = rd & ~wr;
  endtask

  task automatic idle_in;
    valid_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; regwr_in = 1'b0; mem2reg_in = 1'b0;
  endtask

  initial begin
    rst = 1'b0; bus_ack = 1'b0; bus_rdata = '0; dst_reg = 5'd0; store_data = '0;
    alu_res = '0; mem_size = 2'b00; mem_sext = 1'b0;
    idle_in();
    regwr_in = 1'b1;
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_rdata", rdata_out, 0);
    chk("rst_err", err, 0);
    chk("rst_regwr", regwr_out, 0);
    tick(); tick();
    rst = 1'b1;

    // ADD pass-through
    alu_res = 32'h1234; regwr_in = 1'b1; valid_in = 1'b1; dst_reg = 5'd5;
    #1;
    chk("add_alu", alu_out, 32'h1234);
    chk("add_regwr", regwr_out, 1);
    chk("add_stall", stall, 0);
    chk("add_dst", dst_out, 5);
    tick();

    // LB sext at 0x103, ack in the 2nd REQ cycle
    op(1, 0, 2'b00, 1, 32'h103, 0); dst_reg = 5'd8;
    #1;
    chk("lb_idle_stall", stall, 1);
    chk("lb_idle_regwr", regwr_out, 0);
    chk("lb_idle_req", bus_req, 0);
    tick();
    chk("lb_req1", bus_req, 1);
    chk("lb_addr", bus_addr, 32'h100);
    chk("lb_be", bus_be, 4'b1000);
    chk("lb_we", bus_we, 0);
    chk("lb_stall1", stall, 1);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h80AABBCC;
    #1;
    chk("lb_stall2", stall, 1);
    tick();
    bus_ack = 1'b0;
    chk("lb_done_data", rdata_out, 32'hFFFFFF80);
    chk("lb_done_stall", stall, 0);
    chk("lb_done_regwr", regwr_out, 1);
    chk("lb_done_req", bus_req, 0);
    chk("lb_done_err", err, 0);
    tick();
    idle_in();
    #1;
    chk("lb_cleared", rdata_out, 0);

    // SH at 0x202
    op(0, 1, 2'b01, 0, 32'h202, 32'h0000BEEF);
    #1;
    chk("sh_stall", stall, 1);
    tick();
    chk("sh_we", bus_we, 1);
    chk("sh_be", bus_be, 4'b1100);
    chk("sh_wdata", bus_wdata, 32'hBEEFBEEF);
    chk("sh_addr", bus_addr, 32'h200);
    bus_ack = 1'b1; bus_rdata = 32'hDEADDEAD;
    tick();
    bus_ack = 1'b0;
    chk("sh_done_stall", stall, 0);
    chk("sh_done_rdata", rdata_out, 0);
    chk("sh_done_req", bus_req, 0);
    tick();
    idle_in();
    #1;
    chk("sh_after_stall", stall, 0);

    // Byte store lane 1, halfword loads with and without extension
    op(0, 1, 2'b00, 0, 32'h401, 32'h000000A5);
    tick();
    chk("sb_be", bus_be, 4'b0010);
    chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
    bus_ack = 1'b1; tick(); bus_ack = 1'b0; tick();
    op(1, 0, 2'b01, 0, 32'h2, 0);
    tick();
    chk("lhu_be", bus_be, 4'b1100);
    bus_ack = 1'b1; bus_rdata = 32'h80AABBCC; tick(); bus_ack = 1'b0;
    chk("lhu_data", rdata_out, 32'h000080AA);
    tick();
    op(1, 0, 2'b01, 1, 32'h0, 0);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h1234F00D; tick(); bus_ack = 1'b0;
    chk("lh_data", rdata_out, 32'hFFFFF00D);
    tick();

    // Timeout: 4 REQ cycles with no ack
    op(1, 0, 2'b10, 0, 32'h40, 0);
    tick();
    for (int i = 0; i < TO; i++) begin
      chk($sformatf("to_req%0d", i), bus_req, 1);
      if (i < TO - 1) tick();
    end
    tick();
    chk("to_done_req", bus_req, 0);
    chk("to_done_err", err, 1);
    chk("to_done_regwr", regwr_out, 0);
    chk("to_done_rdata", rdata_out, 0);
    chk("to_done_stall", stall, 0);
    tick();
    idle_in();
    #1;
    chk("to_err_pulse", err, 0);

    // Ack in the last allowed REQ cycle beats the timeout
    op(1, 0, 2'b10, 0, 32'h44, 0);
    tick(); tick(); tick(); tick();
    bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
    tick();
    bus_ack = 1'b0;
    chk("to_race_err", err, 0);
    chk("to_race_data", rdata_out, 32'h0BADF00D);
    chk("to_race_regwr", regwr_out, 1);
    tick();

    // rd and wr together act as a store
    op(1, 1, 2'b10, 0, 32'h30, 32'h11223344);
    tick();
    chk("rw_we", bus_we, 1);
    chk("rw_wdata", bus_wdata, 32'h11223344);
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF; tick(); bus_ack = 1'b0;
    chk("rw_rdata", rdata_out, 0);
    tick();

    // Stray ack while idle
    idle_in();
    bus_ack = 1'b1; bus_rdata = 32'h55555555;
    tick();
    bus_ack = 1'b0;
    chk("stray_rdata", rdata_out, 0);
    chk("stray_stall", stall, 0);

    // Reset in REQ, then a fresh LW
    op(1, 0, 2'b10, 0, 32'h20, 0);
    tick();
    chk("rr_req", bus_req, 1);
    rst = 1'b0;
    #1;
    chk("rr_req_drop", bus_req, 0);
    chk("rr_stall", stall, 0);
    chk("rr_regwr", regwr_out, 0);
    chk("rr_addr", bus_addr, 0);
    idle_in();
    tick();
    rst = 1'b1;
    op(1, 0, 2'b10, 0, 32'h10, 0);
    #1;
    chk("rr_idle_stall", stall, 1);
    tick();
    chk("rr_lw_addr", bus_addr, 32'h10);
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    tick();
    bus_ack = 1'b0;
    chk("rr_lw_data", rdata_out, 32'h12345678);
    chk("rr_lw_err", err, 0);
    tick();

    // LW at misaligned 0x6
    op(1, 0, 2'b10, 0, 32'h6, 0);
`ifdef MEM_ALIGN_TRAP_EN
    tick();
    chk("mis_req", bus_req, 0);
    chk("mis_err", err, 1);
    chk("mis_regwr", regwr_out, 0);
    chk("mis_rdata", rdata_out, 0);
`else
    tick();
    chk("mis_addr", bus_addr, 32'h4);
    chk("mis_be", bus_be, 4'b1111);
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    tick();
    bus_ack = 1'b0;
    chk("mis_data", rdata_out, 32'hCAFEF00D);
    chk("mis_err", err, 0);
`endif
    tick();
    idle_in();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
